// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Receives a start-bit framed serial stream one qualified bit at a time,
//   assembles a WIDTH-bit word, checks the optional parity bit and the stop
//   bit, and hands the word to a valid/ready consumer through a one-entry
//   holding register.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   bit_in      serial data bit
//   bit_valid   bit_in is sampled only when this is 1
//   data_out    received word (held while data_valid=1)
//   data_valid  holding register contains an unconsumed word
//   data_ready  consumer accepts data_out
//   busy        a frame is in progress
//   parity_err  one-cycle pulse: parity mismatch, word dropped
//   frame_err   one-cycle pulse: stop bit was 0, word dropped
//   overrun     one-cycle pulse: good word arrived while holding reg full
//   frame_cnt   number of good words loaded into the holding register (wraps)
module serial_frame_rx #(
  parameter int WIDTH      = 4,
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic [7:0]       frame_cnt
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_bad_q, par_bad_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic [7:0]       fcnt_q, fcnt_d;
  logic             hold_free;

  // The holding register can accept a new word if it is empty, or if the
  // consumer is draining it on this very cycle.
  assign hold_free = ~valid_q | data_ready;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    hold_d    = hold_q;
    valid_d   = valid_q & ~data_ready;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    fcnt_d    = fcnt_q;

    if (bit_valid) begin
      case (state_q)
        S_IDLE: begin
          // A high line is idle; a low bit is the start bit.
          if (!bit_in) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
            par_bad_d = 1'b0;
          end
        end
        S_DATA: begin
          // LSB-first shifts in at the top so the first bit ends in bit 0.
          if (MSB_FIRST != 0) shift_d = {shift_q[WIDTH-2:0], bit_in};
          else                shift_d = {bit_in, shift_q[WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CW'(WIDTH - 1))
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          par_bad_d = (^shift_q) ^ (ODD_PARITY != 0) ^ bit_in;
          state_d   = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!bit_in) begin
            ferr_d = 1'b1;
          end else if (par_bad_q) begin
            perr_d = 1'b1;
          end else if (hold_free) begin
            hold_d  = shift_q;
            valid_d = 1'b1;
            fcnt_d  = fcnt_q + 8'd1;
          end else begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign data_out   = hold_q;
  assign data_valid = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Testbench for serial_frame_rx (WIDTH=4, LSB-first, even parity).
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_in = 1'b1;
  logic       bit_valid = 1'b0;
  logic [3:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b0;
  logic       busy, parity_err, frame_err, overrun;
  logic [7:0] frame_cnt;

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Reference model of the holding register and counters.
  logic       m_valid;
  logic [3:0] m_data;
  logic [7:0] m_cnt;
  logic       e_perr, e_ferr, e_ovr;

  serial_frame_rx #(.WIDTH(4), .MSB_FIRST(0), .PARITY_EN(1), .ODD_PARITY(0)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame bits in transmit order: start, d0..d3, parity, stop.
  function automatic logic [6:0] mk_bits(input logic [3:0] w, input logic pflip, input logic stop);
    logic par;
    par = (^w) ^ pflip;
    return {stop, par, w, 1'b0};
  endfunction

  task automatic send_bit(input logic b, input int gap, input logic rdy);
    repeat (gap) begin
      bit_valid = 1'b0;
      tick();
    end
    data_ready = rdy;
    bit_in     = b;
    bit_valid  = 1'b1;
    tick();
    bit_valid  = 1'b0;
    bit_in     = 1'b1;
    data_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] w, input logic pflip, input logic stop,
                            input int gmin, input int gmax, input logic rdy_at_stop);
    logic [6:0] bits;
    bits = mk_bits(w, pflip, stop);
    for (int i = 0; i < 7; i++)
      send_bit(bits[i], $urandom_range(gmax, gmin), (i == 6) ? rdy_at_stop : 1'b0);
    $display("frame w=%b pflip=%0d stop=%0d rdy=%0d -> valid=%0d out=%b cnt=%0d perr=%0d ferr=%0d ovr=%0d",
             w, pflip, stop, rdy_at_stop, data_valid, data_out, frame_cnt, parity_err, frame_err, overrun);
  endtask

  // Expected outcome of one frame, from the receive rules.
  task automatic model_frame(input logic [3:0] w, input logic pflip, input logic stop, input logic rdy);
    logic good, free;
    good   = stop && !pflip;
    free   = !m_valid || rdy;
    e_ferr = !stop;
    e_perr = stop && pflip;
    e_ovr  = good && !free;
    if (rdy) m_valid = 1'b0;
    if (good && free) begin
      m_valid = 1'b1;
      m_data  = w;
      m_cnt   = m_cnt + 8'd1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_valid = 1'b0;
    m_data  = 4'd0;
    m_cnt   = 8'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin
      bit_in     = 1'($urandom);
      bit_valid  = 1'($urandom);
      data_ready = 1'($urandom);
      tick();
    end
    rst = 1'b0; bit_in = 1'b1; bit_valid = 1'b0; data_ready = 1'b0;
    chk_cnt++; if (data_out !== 4'd0) $display("FAIL reset_data_out got %b want 0000", data_out); else pass_cnt++;
    chk_cnt++; if (data_valid !== 1'b0) $display("FAIL reset_data_valid got %b want 0", data_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if ({parity_err, frame_err, overrun} !== 3'b000)
      $display("FAIL reset_pulses got %b want 000", {parity_err, frame_err, overrun}); else pass_cnt++;
    chk_cnt++; if (frame_cnt !== 8'd0) $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); else pass_cnt++;
    m_valid = 1'b0; m_data = 4'd0; m_cnt = 8'd0;
  endtask

  task automatic test_good_frame();
    logic [6:0] bits;
    do_reset();
    bits = mk_bits(4'b1011, 1'b0, 1'b1);
    send_bit(bits[0], 0, 1'b0);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL good_busy_after_start got %b want 1", busy); else pass_cnt++;
    for (int i = 1; i < 7; i++) send_bit(bits[i], 0, 1'b0);
    $display("good frame -> valid=%0d out=%b cnt=%0d", data_valid, data_out, frame_cnt);
    chk_cnt++; if (data_valid !== 1'b1) $display("FAIL good_valid got %b want 1", data_valid); else pass_cnt++;
    chk_cnt++; if (data_out !== 4'b1011) $display("FAIL good_data got %b want 1011", data_out); else pass_cnt++;
    chk_cnt++; if (frame_cnt !== 8'd1) $display("FAIL good_cnt got %0d want 1", frame_cnt); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL good_busy_after_stop got %b want 0", busy); else pass_cnt++;
    tick();
    chk_cnt++; if (data_valid !== 1'b1) $display("FAIL good_valid_held got %b want 1", data_valid); else pass_cnt++;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    chk_cnt++; if (data_valid !== 1'b0) $display("FAIL good_consumed got %b want 0", data_valid); else pass_cnt++;
  endtask

  task automatic test_parity_err();
    do_reset();
    send_frame(4'b1011, 1'b1, 1'b1, 0, 0, 1'b0);
    chk_cnt++; if (parity_err !== 1'b1) $display("FAIL perr_pulse got %b want 1", parity_err); else pass_cnt++;
    chk_cnt++; if (data_valid !== 1'b0) $display("FAIL perr_valid got %b want 0", data_valid); else pass_cnt++;
    chk_cnt++; if (frame_cnt !== 8'd0) $display("FAIL perr_cnt got %0d want 0", frame_cnt); else pass_cnt++;
    tick();
    chk_cnt++; if (parity_err !== 1'b0) $display("FAIL perr_one_cycle got %b want 0", parity_err); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    do_reset();
    send_frame(4'b1011, 1'b0, 1'b0, 0, 0, 1'b0);
    chk_cnt++; if (frame_err !== 1'b1) $display("FAIL ferr_pulse got %b want 1", frame_err); else pass_cnt++;
    chk_cnt++; if (data_valid !== 1'b0) $display("FAIL ferr_valid got %b want 0", data_valid); else pass_cnt++;
    send_frame(4'b1011, 1'b0, 1'b1, 0, 0, 1'b0);
    chk_cnt++; if (data_valid !== 1'b1 || data_out !== 4'b1011)
      $display("FAIL ferr_next_frame got valid=%b out=%b want 1/1011", data_valid, data_out); else pass_cnt++;
    chk_cnt++; if (frame_cnt !== 8'd1) $display("FAIL ferr_next_cnt got %0d want 1", frame_cnt); else pass_cnt++;
    chk_cnt++; if (frame_err !== 1'b0) $display("FAIL ferr_next_noerr got %b want 0", frame_err); else pass_cnt++;
  endtask

  task automatic test_overrun();
    do_reset();
    send_frame(4'b1011, 1'b0, 1'b1, 0, 0, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b1, 0, 0, 1'b0);
    chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_pulse got %b want 1", overrun); else pass_cnt++;
    chk_cnt++; if (data_out !== 4'b1011) $display("FAIL ovr_data_held got %b want 1011", data_out); else pass_cnt++;
    chk_cnt++; if (frame_cnt !== 8'd1) $display("FAIL ovr_cnt got %0d want 1", frame_cnt); else pass_cnt++;
    chk_cnt++; if (data_valid !== 1'b1) $display("FAIL ovr_valid got %b want 1", data_valid); else pass_cnt++;
    tick();
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_one_cycle got %b want 0", overrun); else pass_cnt++;
    send_frame(4'b0110, 1'b0, 1'b1, 0, 0, 1'b1);
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL same_cycle_no_ovr got %b want 0", overrun); else pass_cnt++;
    chk_cnt++; if (data_out !== 4'b0110 || data_valid !== 1'b1)
      $display("FAIL same_cycle_load got valid=%b out=%b want 1/0110", data_valid, data_out); else pass_cnt++;
    chk_cnt++; if (frame_cnt !== 8'd2) $display("FAIL same_cycle_cnt got %0d want 2", frame_cnt); else pass_cnt++;
  endtask

  task automatic test_gaps();
    do_reset();
    send_frame(4'b1011, 1'b0, 1'b1, 1, 3, 1'b0);
    chk_cnt++; if (data_valid !== 1'b1 || data_out !== 4'b1011)
      $display("FAIL gaps_frame got valid=%b out=%b want 1/1011", data_valid, data_out); else pass_cnt++;
    chk_cnt++; if (frame_cnt !== 8'd1) $display("FAIL gaps_cnt got %0d want 1", frame_cnt); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_frame(4'b0101, 1'b0, 1'b1, 0, 0, 1'b0);
    send_bit(1'b0, 0, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL midrst_busy_before got %b want 1", busy); else pass_cnt++;
    do_reset();
    chk_cnt++; if (busy !== 1'b0 || data_valid !== 1'b0 || frame_cnt !== 8'd0)
      $display("FAIL midrst_cleared got busy=%b valid=%b cnt=%0d want 0/0/0", busy, data_valid, frame_cnt); else pass_cnt++;
    send_frame(4'b1011, 1'b0, 1'b1, 0, 0, 1'b0);
    chk_cnt++; if (data_valid !== 1'b1 || data_out !== 4'b1011 || frame_cnt !== 8'd1)
      $display("FAIL midrst_next got valid=%b out=%b cnt=%0d want 1/1011/1", data_valid, data_out, frame_cnt); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [3:0] w;
    logic pflip, stop, rdy;
    do_reset();
    for (int n = 0; n < 200; n++) begin
      w     = 4'($urandom);
      pflip = ($urandom_range(9, 0) == 0);
      stop  = ($urandom_range(9, 0) != 0);
      rdy   = 1'($urandom);
      model_frame(w, pflip, stop, rdy);
      send_frame(w, pflip, stop, 0, 2, rdy);
      chk_cnt++; if (data_valid !== m_valid) $display("FAIL rand_valid n=%0d got %b want %b", n, data_valid, m_valid); else pass_cnt++;
      if (m_valid) begin
        chk_cnt++; if (data_out !== m_data) $display("FAIL rand_data n=%0d got %b want %b", n, data_out, m_data); else pass_cnt++;
      end
      chk_cnt++; if (frame_cnt !== m_cnt) $display("FAIL rand_cnt n=%0d got %0d want %0d", n, frame_cnt, m_cnt); else pass_cnt++;
      chk_cnt++; if ({parity_err, frame_err, overrun} !== {e_perr, e_ferr, e_ovr})
        $display("FAIL rand_flags n=%0d got %b want %b", n, {parity_err, frame_err, overrun}, {e_perr, e_ferr, e_ovr}); else pass_cnt++;
      if ($urandom_range(2, 0) == 0) begin
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        m_valid = 1'b0;
        chk_cnt++; if (data_valid !== 1'b0) $display("FAIL rand_consume n=%0d got %b want 0", n, data_valid); else pass_cnt++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] w;
    do_reset();
    for (int n = 0; n < 256; n++) begin
      w = 4'($urandom);
      model_frame(w, 1'b0, 1'b1, 1'b1);
      send_frame(w, 1'b0, 1'b1, 0, 0, 1'b1);
      chk_cnt++; if (frame_cnt !== m_cnt || data_out !== m_data)
        $display("FAIL wrap n=%0d got cnt=%0d out=%b want %0d/%b", n, frame_cnt, data_out, m_cnt, m_data); else pass_cnt++;
    end
    chk_cnt++; if (frame_cnt !== 8'd0) $display("FAIL wrap_final got %0d want 0", frame_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_gaps();
    test_mid_reset();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream receive stage for the serial stream produced by the universal shift register's shift-out path.
- Accepts one qualified bit per strobe and detects a start bit.
- Assembles a WIDTH-bit word, checks optional parity and the stop bit, then presents the word on a valid/ready parallel interface through a one-entry holding register.
- Flags parity, framing and overrun errors, and counts good frames.

Parameters:
- WIDTH, 4: data bits per frame. Matches the 4-bit shift register word.
- MSB_FIRST, 0: 0 = first data bit lands in bit 0; 1 = first data bit lands in bit WIDTH-1.
- PARITY_EN, 1: 1 = one parity bit follows the data bits; 0 = no parity bit.
- ODD_PARITY, 0: 0 = even parity expected; 1 = odd parity expected.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is sampled only on cycles where this is 1.
- data_out  out  WIDTH  received word.
- data_valid  out  1  data_out holds an unconsumed word.
- data_ready  in  1  consumer accepts data_out.
- busy  out  1  frame in progress (state != IDLE).
- parity_err  out  1  one-cycle pulse.
- frame_err  out  1  one-cycle pulse.
- overrun  out  1  one-cycle pulse.
- frame_cnt  out  8  count of good frames delivered to the holding register; wraps 255 -> 0.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - On rst=1 at a clk edge: all outputs are 0, data_out=0, state=IDLE, bit counter=0, shift register=0.
  - rst has priority over every other input, including mid-frame; a partial frame is discarded.
- States: IDLE, DATA, PARITY, STOP. Transitions occur only on cycles with bit_valid=1; with bit_valid=0 the state, counter and shift register hold.
- IDLE:
  - bit_in=1 is ignored (line idle high).
  - bit_in=0 is the start bit -> DATA, counter=0.
- DATA:
  - Each valid bit is stored per MSB_FIRST; the counter increments.
  - After the WIDTH-th bit: -> PARITY if PARITY_EN=1, else -> STOP.
- PARITY:
  - Expected parity bit = XOR of the WIDTH data bits, XOR ODD_PARITY.
  - The mismatch result is latched internally; state -> STOP.
- STOP, on the valid stop bit (state -> IDLE in every case), first matching case applies:
  - stop=0: frame_err pulses; word dropped.
  - stop=1 with parity mismatch: parity_err pulses; word dropped.
  - stop=1, parity good, holding register free: word loaded, frame_cnt+1.
  - stop=1, parity good, holding register full: overrun pulses; new word dropped; held data_out unchanged; frame_cnt unchanged.
- Holding register free: data_valid=0, or data_valid=1 and data_ready=1 in the same cycle. The same-cycle consume-and-load case is not an overrun.
- Latency:
  - data_valid rises on the clk edge that samples the stop bit, i.e. visible the cycle after the stop bit is presented.
  - Error pulses are registered on that same edge and last exactly one cycle.
- Handshake:
  - data_valid stays 1 and data_out stays stable until a cycle with data_ready=1, after which data_valid=0 (unless reloaded that cycle).
  - data_ready while data_valid=0 has no effect.
- busy is 1 from the cycle after the start bit is sampled through the edge that samples the stop bit.
- A start bit is detectable on the very next valid bit after a stop bit; no idle bits are required.
- frame_cnt is 8-bit unsigned and wraps without a flag.

Test Plan:
1. Reset check: hold rst=1 for 2 cycles, random bit_in/bit_valid -> all outputs 0, busy=0.
2. Good frame (WIDTH=4, even parity, LSB-first), bits 0,1,1,0,1,1,1 with data_ready=0:
   - Cycle after the stop bit: data_valid=1, data_out=4'b1011, frame_cnt=1.
   - Then data_ready=1 for one cycle -> data_valid=0.
3. Parity error: bits 0,1,1,0,1,0,1 -> parity_err pulses one cycle; data_valid stays 0; frame_cnt unchanged.
4. Framing error: bits 0,1,1,0,1,1,0 -> frame_err pulses; no data_valid.
   - Sending the next good frame immediately afterwards is received correctly.
5. Overrun and same-cycle free:
   - Frame 1011 with data_ready=0, then frame 0110 (bits 0,0,1,1,0,0,1) -> overrun pulses; data_out stays 4'b1011; frame_cnt=1.
   - Repeat with data_ready=1 on the second stop-bit cycle -> no overrun; data_out=4'b0110.
6. Gaps and mid-frame reset:
   - A good frame with bit_valid=0 gaps of 1-3 cycles between bits -> same result as scenario 2.
   - Assert rst for one cycle after 2 data bits -> busy=0; a following frame 1011 is received correctly with frame_cnt=1.
